// File: rtl/pending_garbage_manager_pkg.sv
// Shared types and limits for the pending-garbage path.
// Consumed by the manager, the hole generator and the display bar scaler.
package pending_garbage_manager_pkg;

  localparam int GARBAGE_WIDTH   = 5;
  localparam int PENDING_MAX     = 20;
  localparam int APPLY_CAP       = 8;
  localparam int PLAYFIELD_WIDTH = 10;

  localparam logic [3:0] LFSR_SEED = 4'b0001;

  typedef logic [GARBAGE_WIDTH-1:0] lines_t;

  typedef enum logic {
    GARBAGE_IDLE,
    GARBAGE_APPLY
  } garbage_state_t;

  // Saturating add done one bit wider so 31 + 31 cannot wrap.
  function automatic lines_t sat_add(
    input lines_t x,
    input lines_t y,
    input lines_t lim
  );
    logic [GARBAGE_WIDTH:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s > {1'b0, lim}) return lim;
    return s[GARBAGE_WIDTH-1:0];
  endfunction

  function automatic lines_t min_lines(
    input lines_t x,
    input lines_t y
  );
    return (x < y) ? x : y;
  endfunction

endpackage

// File: rtl/pending_garbage_manager_hole_lfsr.sv
// Hole column generator: 4-bit x^4+x^3+1 LFSR reduced mod the board width.
// Ports: clk, rst_l (async low), clear (sync reseed), hole[3:0].
import pending_garbage_manager_pkg::*;

module hole_lfsr #(
  parameter int WIDTH = PLAYFIELD_WIDTH
) (
  input  logic       clk,
  input  logic       rst_l,
  input  logic       clear,
  output logic [3:0] hole
);

  localparam logic [3:0] W4 = 4'(WIDTH);

  logic [3:0] lfsr_q;
  logic [3:0] lfsr_d;

  // Shift left, feed back taps 4 and 3; period 15, never hits zero.
  assign lfsr_d = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      lfsr_q <= LFSR_SEED;
    end else if (clear) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // Raw range is 1..15, so one conditional subtract is a full modulo.
  assign hole = (lfsr_q >= W4) ? (lfsr_q - W4) : lfsr_q;

endmodule

// File: rtl/pending_garbage_manager.sv
// Pending-garbage accumulator: cancels incoming garbage with own attacks,
// forwards leftover attack, and releases capped batches on clean locks.
// Ports: clk, rst_l, game_start, recv_*, attack_*, lock_*, send_*,
//        apply_* (valid/ready to loader), pending_garbage (display bar).
import pending_garbage_manager_pkg::*;

module pending_garbage_manager #(
  parameter int PENDING_MAX     = pending_garbage_manager_pkg::PENDING_MAX,
  parameter int APPLY_CAP       = pending_garbage_manager_pkg::APPLY_CAP,
  parameter int PLAYFIELD_WIDTH = pending_garbage_manager_pkg::PLAYFIELD_WIDTH
) (
  input  logic       clk,
  input  logic       rst_l,
  input  logic       game_start,
  input  logic       recv_valid,
  input  logic [4:0] recv_lines,
  input  logic       attack_valid,
  input  logic [4:0] attack_lines,
  input  logic       lock_valid,
  input  logic       lock_cleared,
  output logic       send_valid,
  output logic [4:0] send_lines,
  output logic       apply_valid,
  output logic [4:0] apply_lines,
  output logic [3:0] apply_hole,
  input  logic       apply_ready,
  output logic [4:0] pending_garbage
);

  localparam lines_t PMAX = lines_t'(PENDING_MAX);
  localparam lines_t CAP  = lines_t'(APPLY_CAP);

  garbage_state_t state_q, state_d;

  lines_t     pend_q, pend_d;
  logic       send_v_q, send_v_d;
  lines_t     send_l_q, send_l_d;
  lines_t     app_l_q, app_l_d;
  logic [3:0] app_h_q, app_h_d;

  lines_t     atk;
  lines_t     rcv;
  lines_t     cancelled;
  lines_t     over;
  lines_t     p1;
  lines_t     batch;
  logic [3:0] hole;

  hole_lfsr #(
    .WIDTH (PLAYFIELD_WIDTH)
  ) u_hole (
    .clk   (clk),
    .rst_l (rst_l),
    .clear (game_start),
    .hole  (hole)
  );

  // Attack cancels what is already queued; new garbage lands afterwards.
  always_comb begin
    atk       = attack_valid ? attack_lines : '0;
    rcv       = recv_valid ? recv_lines : '0;
    cancelled = (atk > pend_q) ? '0 : (pend_q - atk);
    over      = (atk > pend_q) ? (atk - pend_q) : '0;
    p1        = sat_add(cancelled, rcv, PMAX);
    batch     = min_lines(p1, CAP);
  end

  always_comb begin
    state_d  = state_q;
    pend_d   = p1;
    send_v_d = (over != '0);
    send_l_d = over;
    app_l_d  = app_l_q;
    app_h_d  = app_h_q;

    unique case (state_q)
      GARBAGE_IDLE: begin
        if (lock_valid && !lock_cleared && (p1 != '0)) begin
          pend_d  = p1 - batch;
          app_l_d = batch;
          app_h_d = hole;
          state_d = GARBAGE_APPLY;
        end
      end
      GARBAGE_APPLY: begin
        // Batch is already out of the pending count; lock is ignored here.
        if (apply_ready) begin
          app_l_d = '0;
          app_h_d = '0;
          state_d = GARBAGE_IDLE;
        end
      end
      default: begin
        state_d = GARBAGE_IDLE;
      end
    endcase

    if (game_start) begin
      state_d  = GARBAGE_IDLE;
      pend_d   = '0;
      send_v_d = 1'b0;
      send_l_d = '0;
      app_l_d  = '0;
      app_h_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q  <= GARBAGE_IDLE;
      pend_q   <= '0;
      send_v_q <= 1'b0;
      send_l_q <= '0;
      app_l_q  <= '0;
      app_h_q  <= '0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      send_v_q <= send_v_d;
      send_l_q <= send_l_d;
      app_l_q  <= app_l_d;
      app_h_q  <= app_h_d;
    end
  end

  assign send_valid      = send_v_q;
  assign send_lines      = send_l_q;
  assign apply_valid     = (state_q == GARBAGE_APPLY);
  assign apply_lines     = app_l_q;
  assign apply_hole      = app_h_q;
  assign pending_garbage = pend_q;

endmodule

// File: tb/tb_pending_garbage_manager.sv
// Self-checking bench for pending_garbage_manager.
// Reference model works on plain integers and a 15-entry LFSR sequence.
module tb_pending_garbage_manager;

  logic       clk = 1'b0;
  logic       rst_l = 1'b0;
  logic       game_start = 1'b0;
  logic       recv_valid = 1'b0;
  logic [4:0] recv_lines = '0;
  logic       attack_valid = 1'b0;
  logic [4:0] attack_lines = '0;
  logic       lock_valid = 1'b0;
  logic       lock_cleared = 1'b0;
  logic       send_valid;
  logic [4:0] send_lines;
  logic       apply_valid;
  logic [4:0] apply_lines;
  logic [3:0] apply_hole;
  logic       apply_ready = 1'b0;
  logic [4:0] pending_garbage;

  int checks = 0;
  int failures = 0;

  // x^4+x^3+1 sequence starting at seed 1
  int lfsr_seq [15] = '{1, 2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8};

  int  m_p;
  bit  m_inf;
  int  m_lines;
  int  m_hole;
  bit  m_sv;
  int  m_sl;
  int  m_idx;

  always #5 clk = ~clk;

  pending_garbage_manager dut (
    .clk             (clk),
    .rst_l           (rst_l),
    .game_start      (game_start),
    .recv_valid      (recv_valid),
    .recv_lines      (recv_lines),
    .attack_valid    (attack_valid),
    .attack_lines    (attack_lines),
    .lock_valid      (lock_valid),
    .lock_cleared    (lock_cleared),
    .send_valid      (send_valid),
    .send_lines      (send_lines),
    .apply_valid     (apply_valid),
    .apply_lines     (apply_lines),
    .apply_hole      (apply_hole),
    .apply_ready     (apply_ready),
    .pending_garbage (pending_garbage)
  );

  task automatic model_clear();
    m_p = 0; m_inf = 0; m_lines = 0; m_hole = 0;
    m_sv = 0; m_sl = 0; m_idx = 0;
  endtask

  task automatic idle_inputs();
    game_start = 0; recv_valid = 0; recv_lines = 0;
    attack_valid = 0; attack_lines = 0;
    lock_valid = 0; lock_cleared = 0; apply_ready = 0;
  endtask

  // Advance model by one clock using the current inputs, then clock DUT.
  task automatic tick();
    int a, r, p1, n;
    if (game_start) begin
      model_clear();
    end else begin
      a = attack_valid ? int'(attack_lines) : 0;
      r = recv_valid ? int'(recv_lines) : 0;
      m_sv = (a > m_p);
      m_sl = (a > m_p) ? a - m_p : 0;
      p1 = ((a > m_p) ? 0 : m_p - a) + r;
      if (p1 > 20) p1 = 20;
      if (!m_inf) begin
        if (lock_valid && !lock_cleared && p1 > 0) begin
          n = (p1 < 8) ? p1 : 8;
          m_p = p1 - n;
          m_lines = n;
          m_hole = lfsr_seq[m_idx] % 10;
          m_inf = 1;
        end else begin
          m_p = p1;
        end
      end else begin
        m_p = p1;
        if (apply_ready) m_inf = 0;
      end
      m_idx = (m_idx + 1) % 15;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_l = 0;
    idle_inputs();
    model_clear();
    #2;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_l = 1;
  endtask

  task automatic pulse_start();
    idle_inputs();
    game_start = 1;
    tick();
    game_start = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (pending_garbage !== 5'd0) begin
      failures++;
      $display("FAIL reset_pending act=%0d exp=0", pending_garbage);
    end
    checks++;
    if (send_valid !== 1'b0 || send_lines !== 5'd0) begin
      failures++;
      $display("FAIL reset_send act=%0b/%0d exp=0/0", send_valid, send_lines);
    end
    checks++;
    if (apply_valid !== 1'b0 || apply_lines !== 5'd0 || apply_hole !== 4'd0) begin
      failures++;
      $display("FAIL reset_apply act=%0b/%0d/%0d exp=0/0/0",
               apply_valid, apply_lines, apply_hole);
    end
    release_reset();
  endtask

  task automatic test_recv();
    pulse_start();
    recv_valid = 1; recv_lines = 3;
    tick();
    idle_inputs();
    checks++;
    if (pending_garbage !== 5'd3) begin
      failures++;
      $display("FAIL recv3 act=%0d exp=3", pending_garbage);
    end
    recv_valid = 1; recv_lines = 30;
    tick();
    idle_inputs();
    checks++;
    if (pending_garbage !== 5'd20 || send_valid !== 1'b0) begin
      failures++;
      $display("FAIL recv_sat act=%0d/%0b exp=20/0", pending_garbage, send_valid);
    end
  endtask

  task automatic test_cancel();
    pulse_start();
    recv_valid = 1; recv_lines = 5;
    tick();
    idle_inputs();
    attack_valid = 1; attack_lines = 2;
    tick();
    idle_inputs();
    checks++;
    if (pending_garbage !== 5'd3 || send_valid !== 1'b0) begin
      failures++;
      $display("FAIL cancel2 act=%0d/%0b exp=3/0", pending_garbage, send_valid);
    end
    attack_valid = 1; attack_lines = 7;
    tick();
    idle_inputs();
    checks++;
    if (pending_garbage !== 5'd0 || send_valid !== 1'b1 || send_lines !== 5'd4) begin
      failures++;
      $display("FAIL cancel7 act=%0d/%0b/%0d exp=0/1/4",
               pending_garbage, send_valid, send_lines);
    end
    tick();
    checks++;
    if (send_valid !== 1'b0) begin
      failures++;
      $display("FAIL send_pulse act=%0b exp=0", send_valid);
    end
  endtask

  task automatic test_cancel_before_add();
    pulse_start();
    recv_valid = 1; recv_lines = 4;
    tick();
    recv_lines = 3;
    attack_valid = 1; attack_lines = 6;
    tick();
    idle_inputs();
    checks++;
    if (pending_garbage !== 5'd3 || send_valid !== 1'b1 || send_lines !== 5'd2) begin
      failures++;
      $display("FAIL cancel_add act=%0d/%0b/%0d exp=3/1/2",
               pending_garbage, send_valid, send_lines);
    end
  endtask

  task automatic test_apply();
    pulse_start();
    recv_valid = 1; recv_lines = 12;
    tick();
    idle_inputs();
    lock_valid = 1;
    tick();
    idle_inputs();
    checks++;
    if (apply_valid !== 1'b1 || apply_lines !== 5'd8 || pending_garbage !== 5'd4) begin
      failures++;
      $display("FAIL apply_entry act=%0b/%0d/%0d exp=1/8/4",
               apply_valid, apply_lines, pending_garbage);
    end
    checks++;
    if (apply_hole !== 4'(m_hole)) begin
      failures++;
      $display("FAIL apply_hole act=%0d exp=%0d", apply_hole, m_hole);
    end
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin recv_valid = 1; recv_lines = 2; end
      if (i == 3) lock_valid = 1;
      tick();
      idle_inputs();
      checks++;
      if (apply_valid !== 1'b1 || apply_lines !== 5'd8 || apply_hole !== 4'(m_hole)) begin
        failures++;
        $display("FAIL stall_hold i=%0d act=%0b/%0d/%0d exp=1/8/%0d",
                 i, apply_valid, apply_lines, apply_hole, m_hole);
      end
    end
    checks++;
    if (pending_garbage !== 5'd6) begin
      failures++;
      $display("FAIL stall_recv act=%0d exp=6", pending_garbage);
    end
    apply_ready = 1;
    tick();
    idle_inputs();
    checks++;
    if (apply_valid !== 1'b0 || pending_garbage !== 5'd6) begin
      failures++;
      $display("FAIL apply_done act=%0b/%0d exp=0/6", apply_valid, pending_garbage);
    end
    lock_valid = 1; lock_cleared = 1;
    tick();
    idle_inputs();
    checks++;
    if (apply_valid !== 1'b0 || pending_garbage !== 5'd6) begin
      failures++;
      $display("FAIL lock_cleared act=%0b/%0d exp=0/6", apply_valid, pending_garbage);
    end
    apply_ready = 1;
    tick();
    idle_inputs();
    checks++;
    if (apply_valid !== 1'b0 || pending_garbage !== 5'd6) begin
      failures++;
      $display("FAIL ready_idle act=%0b/%0d exp=0/6", apply_valid, pending_garbage);
    end
  endtask

  task automatic test_mid_abort();
    pulse_start();
    recv_valid = 1; recv_lines = 9;
    lock_valid = 1;
    tick();
    idle_inputs();
    checks++;
    if (apply_valid !== 1'b1 || apply_lines !== 5'd8 || pending_garbage !== 5'd1) begin
      failures++;
      $display("FAIL abort_setup act=%0b/%0d/%0d exp=1/8/1",
               apply_valid, apply_lines, pending_garbage);
    end
    game_start = 1;
    recv_valid = 1; recv_lines = 5; apply_ready = 1;
    tick();
    idle_inputs();
    checks++;
    if (apply_valid !== 1'b0 || apply_lines !== 5'd0 || apply_hole !== 4'd0 ||
        pending_garbage !== 5'd0 || send_valid !== 1'b0) begin
      failures++;
      $display("FAIL gs_abort act=%0b/%0d/%0d/%0d/%0b exp=0/0/0/0/0",
               apply_valid, apply_lines, apply_hole, pending_garbage, send_valid);
    end
    recv_valid = 1; recv_lines = 10; lock_valid = 1;
    tick();
    idle_inputs();
    apply_reset();
    checks++;
    if (apply_valid !== 1'b0 || apply_lines !== 5'd0 || pending_garbage !== 5'd0) begin
      failures++;
      $display("FAIL rst_abort act=%0b/%0d/%0d exp=0/0/0",
               apply_valid, apply_lines, pending_garbage);
    end
    release_reset();
  endtask

  task automatic test_holes();
    pulse_start();
    for (int k = 0; k < 8; k++) begin
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick();
      recv_valid = 1; recv_lines = 1; lock_valid = 1;
      tick();
      idle_inputs();
      checks++;
      if (apply_valid !== 1'b1 || apply_hole !== 4'(m_hole) || apply_hole >= 4'd10) begin
        failures++;
        $display("FAIL hole k=%0d act=%0b/%0d exp=1/%0d", k, apply_valid, apply_hole, m_hole);
      end
      apply_ready = 1;
      tick();
      idle_inputs();
    end
  endtask

  task automatic test_random();
    pulse_start();
    for (int i = 0; i < 400; i++) begin
      game_start   = ($urandom_range(0, 99) == 0);
      recv_valid   = ($urandom_range(0, 2) == 0);
      recv_lines   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                 : 5'($urandom_range(0, 6));
      attack_valid = ($urandom_range(0, 2) == 0);
      attack_lines = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                 : 5'($urandom_range(0, 6));
      lock_valid   = ($urandom_range(0, 3) == 0);
      lock_cleared = $urandom_range(0, 1) == 1;
      apply_ready  = ($urandom_range(0, 2) == 0);
      tick();
      checks++;
      if (pending_garbage !== 5'(m_p)) begin
        failures++;
        $display("FAIL rnd_pending i=%0d act=%0d exp=%0d", i, pending_garbage, m_p);
      end
      checks++;
      if (send_valid !== m_sv || (m_sv && send_lines !== 5'(m_sl))) begin
        failures++;
        $display("FAIL rnd_send i=%0d act=%0b/%0d exp=%0b/%0d",
                 i, send_valid, send_lines, m_sv, m_sl);
      end
      checks++;
      if (apply_valid !== m_inf ||
          (m_inf && (apply_lines !== 5'(m_lines) || apply_hole !== 4'(m_hole)))) begin
        failures++;
        $display("FAIL rnd_apply i=%0d act=%0b/%0d/%0d exp=%0b/%0d/%0d",
                 i, apply_valid, apply_lines, apply_hole, m_inf, m_lines, m_hole);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_recv();
    test_cancel();
    test_cancel_before_add();
    test_apply();
    test_mid_abort();
    test_holes();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
